// File: rtl/em_pipe_reg.sv
// E-to-M pipeline register: captures execute-stage results each cycle, with stall (hold) and flush (bubble).
// Optional EM_BUBBLE_CNT_EN adds a saturating count of flush edges on port bubble_cnt.
module em_pipe_reg #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] E_instr,
    input  logic [31:0] E_PC,
    input  logic [31:0] E_ALUout,
    input  logic [31:0] E_RD2,
    input  logic [4:0]  E_A3,
    input  logic [1:0]  E_Tnew,
    input  logic        E_link,
    output logic [31:0] M_instr,
    output logic [31:0] M_PC,
    output logic [31:0] M_ALUout,
    output logic [31:0] M_RD2,
    output logic [4:0]  M_A3,
    output logic [31:0] M_fwd,
    output logic [1:0]  M_Tnew_r,
    output logic        M_valid
`ifdef EM_BUBBLE_CNT_EN
    ,
    output logic [31:0] bubble_cnt
`endif
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] rd2_q, rd2_d;
    logic [4:0]  a3_q, a3_d;
    logic [31:0] fwd_q, fwd_d;
    logic [1:0]  tnew_q, tnew_d;
    logic        valid_q, valid_d;

    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        alu_d   = alu_q;
        rd2_d   = rd2_q;
        a3_d    = a3_q;
        fwd_d   = fwd_q;
        tnew_d  = tnew_q;
        valid_d = valid_q;
        if (flush) begin
            // The PC still advances on a bubble so traces show where it came from.
            instr_d = NOP_INSTR;
            pc_d    = E_PC;
            alu_d   = 32'd0;
            rd2_d   = 32'd0;
            a3_d    = 5'd0;
            fwd_d   = 32'd0;
            tnew_d  = 2'd0;
            valid_d = 1'b0;
        end else if (!stall) begin
            instr_d = E_instr;
            pc_d    = E_PC;
            alu_d   = E_ALUout;
            rd2_d   = E_RD2;
            a3_d    = E_A3;
            fwd_d   = E_link ? (E_PC + 32'd8) : E_ALUout;
            tnew_d  = (E_Tnew == 2'd0) ? 2'd0 : (E_Tnew - 2'd1);
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q <= NOP_INSTR;
            pc_q    <= RESET_PC;
            alu_q   <= 32'd0;
            rd2_q   <= 32'd0;
            a3_q    <= 5'd0;
            fwd_q   <= 32'd0;
            tnew_q  <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            alu_q   <= alu_d;
            rd2_q   <= rd2_d;
            a3_q    <= a3_d;
            fwd_q   <= fwd_d;
            tnew_q  <= tnew_d;
            valid_q <= valid_d;
        end
    end

    assign M_instr  = instr_q;
    assign M_PC     = pc_q;
    assign M_ALUout = alu_q;
    assign M_RD2    = rd2_q;
    assign M_A3     = a3_q;
    assign M_fwd    = fwd_q;
    assign M_Tnew_r = tnew_q;
    assign M_valid  = valid_q;

`ifdef EM_BUBBLE_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    // Counts every flush edge, stalled or not, and sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (flush && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bubble_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_em_pipe_reg.sv
// Directed bench for em_pipe_reg: a behavioural model checked every cycle plus literal expectations.
// Build with EM_BUBBLE_CNT_EN defined to also cover the bubble counter.
module tb_em_pipe_reg;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [31:0] E_instr;
    logic [31:0] E_PC;
    logic [31:0] E_ALUout;
    logic [31:0] E_RD2;
    logic [4:0]  E_A3;
    logic [1:0]  E_Tnew;
    logic        E_link;
    logic [31:0] M_instr;
    logic [31:0] M_PC;
    logic [31:0] M_ALUout;
    logic [31:0] M_RD2;
    logic [4:0]  M_A3;
    logic [31:0] M_fwd;
    logic [1:0]  M_Tnew_r;
    logic        M_valid;
`ifdef EM_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt;
`endif

    em_pipe_reg dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .flush(flush),
        .E_instr(E_instr),
        .E_PC(E_PC),
        .E_ALUout(E_ALUout),
        .E_RD2(E_RD2),
        .E_A3(E_A3),
        .E_Tnew(E_Tnew),
        .E_link(E_link),
        .M_instr(M_instr),
        .M_PC(M_PC),
        .M_ALUout(M_ALUout),
        .M_RD2(M_RD2),
        .M_A3(M_A3),
        .M_fwd(M_fwd),
        .M_Tnew_r(M_Tnew_r),
        .M_valid(M_valid)
`ifdef EM_BUBBLE_CNT_EN
        ,
        .bubble_cnt(bubble_cnt)
`endif
    );

    // clock/reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: expected M-stage contents
    logic [31:0] m_instr, m_pc, m_alu, m_rd2, m_fwd;
    logic [4:0]  m_a3;
    logic [1:0]  m_tnew;
    logic        m_valid;
    longint      m_bubbles;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_instr = 32'h0; m_pc = 32'h0000_3000; m_alu = 32'h0; m_rd2 = 32'h0;
            m_fwd = 32'h0; m_a3 = 5'd0; m_tnew = 2'd0; m_valid = 1'b0; m_bubbles = 0;
        end else if (flush) begin
            m_instr = 32'h0; m_pc = E_PC; m_alu = 32'h0; m_rd2 = 32'h0;
            m_fwd = 32'h0; m_a3 = 5'd0; m_tnew = 2'd0; m_valid = 1'b0;
            if (m_bubbles < 64'h0000_0000_FFFF_FFFF) m_bubbles = m_bubbles + 1;
        end else if (!stall) begin
            longint pc8;
            int     t;
            pc8 = (longint'(E_PC) + 8) % 64'h0000_0001_0000_0000;
            t = int'(E_Tnew) - 1;
            if (t < 0) t = 0;
            m_instr = E_instr; m_pc = E_PC; m_alu = E_ALUout; m_rd2 = E_RD2;
            m_a3 = E_A3; m_valid = 1'b1; m_tnew = 2'(t);
            m_fwd = E_link ? 32'(pc8) : E_ALUout;
        end
    end

    // scoreboard compare, away from the active edge
    always @(negedge clk) begin
        if (check_en) begin
            chk("instr", M_instr, m_instr);
            chk("pc", M_PC, m_pc);
            chk("alu", M_ALUout, m_alu);
            chk("rd2", M_RD2, m_rd2);
            chk("a3", 32'(M_A3), 32'(m_a3));
            chk("fwd", M_fwd, m_fwd);
            chk("tnew", 32'(M_Tnew_r), 32'(m_tnew));
            chk("valid", 32'(M_valid), 32'(m_valid));
`ifdef EM_BUBBLE_CNT_EN
            chk("bubble_cnt", bubble_cnt, 32'(m_bubbles));
`endif
        end
    end

    // driver: apply inputs, then return just after the next rising edge
    task automatic cyc(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] rd2, input logic [4:0] a3, input logic [1:0] tnew,
                       input logic link, input logic st, input logic fl);
        E_instr = instr; E_PC = pc; E_ALUout = alu; E_RD2 = rd2; E_A3 = a3;
        E_Tnew = tnew; E_link = link; stall = st; flush = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_instr"}, M_instr, 32'h0);
        chk({tag, "_pc"}, M_PC, 32'h0000_3000);
        chk({tag, "_alu"}, M_ALUout, 32'h0);
        chk({tag, "_a3"}, 32'(M_A3), 32'h0);
        chk({tag, "_fwd"}, M_fwd, 32'h0);
        chk({tag, "_valid"}, 32'(M_valid), 32'h0);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        E_instr = 32'h0; E_PC = 32'h0; E_ALUout = 32'h0; E_RD2 = 32'h0;
        E_A3 = 5'd0; E_Tnew = 2'd0; E_link = 1'b0;

        // mid-cycle reset pulse must clear without a clock edge
        #7 reset = 1'b0;
        #1 chk_reset_vals("rst_async");
        check_en = 1'b1;
        @(negedge clk);
        #1 reset = 1'b1;

        cyc(32'h3421_0005, 32'h0000_3000, 32'h0000_0005, 32'h0, 5'd1, 2'd1, 1'b0, 1'b0, 1'b0);
        chk("ori_instr", M_instr, 32'h3421_0005);
        chk("ori_fwd", M_fwd, 32'h0000_0005);
        chk("ori_tnew", 32'(M_Tnew_r), 32'h0);
        chk("ori_valid", 32'(M_valid), 32'h1);
        chk("model_ori_fwd", m_fwd, 32'h0000_0005);

        cyc(32'h8C22_0000, 32'h0000_3004, 32'h0000_0010, 32'h0000_0055, 5'd2, 2'd2, 1'b0, 1'b0, 1'b0);
        chk("lw_tnew", 32'(M_Tnew_r), 32'h1);
        chk("lw_a3", 32'(M_A3), 32'h2);
        chk("lw_rd2", M_RD2, 32'h0000_0055);

        cyc(32'h0C00_0C10, 32'h0000_3010, 32'hDEAD_BEEF, 32'h0, 5'd31, 2'd0, 1'b1, 1'b0, 1'b0);
        chk("jal_fwd", M_fwd, 32'h0000_3018);
        chk("jal_alu", M_ALUout, 32'hDEAD_BEEF);
        chk("jal_a3", 32'(M_A3), 32'd31);
        chk("model_jal_fwd", m_fwd, 32'h0000_3018);

        cyc(32'hAC22_0004, 32'h0000_3014, 32'h0000_0104, 32'h1234_5678, 5'd0, 2'd3, 1'b0, 1'b0, 1'b0);
        chk("t3_tnew", 32'(M_Tnew_r), 32'h2);
        chk("t3_a3", 32'(M_A3), 32'h0);

        // inputs change while stalled; outputs must stay frozen
        for (int i = 0; i < 3; i++) begin
            cyc(32'h1111_0000 + 32'(i), 32'h0000_3100 + 32'(i), 32'hA5A5_0000, 32'h5A5A_0000,
                5'd7, 2'd2, 1'b1, 1'b1, 1'b0);
        end
        chk("stall_instr", M_instr, 32'hAC22_0004);
        chk("stall_pc", M_PC, 32'h0000_3014);
        chk("stall_fwd", M_fwd, 32'h0000_0104);

        cyc(32'h2222_0000, 32'h0000_3040, 32'h0000_0099, 32'h0000_0077, 5'd9, 2'd2, 1'b0, 1'b1, 1'b1);
        chk("flush_instr", M_instr, 32'h0);
        chk("flush_a3", 32'(M_A3), 32'h0);
        chk("flush_valid", 32'(M_valid), 32'h0);
        chk("flush_pc", M_PC, 32'h0000_3040);
        chk("flush_fwd", M_fwd, 32'h0);

        cyc(32'h0C00_0000, 32'hFFFF_FFFC, 32'h0000_0001, 32'h0, 5'd31, 2'd0, 1'b1, 1'b0, 1'b0);
        chk("wrap_fwd", M_fwd, 32'h0000_0004);
        chk("model_wrap_fwd", m_fwd, 32'h0000_0004);

        // reset arriving during a stall clears everything
        cyc(32'h3333_0000, 32'h0000_3200, 32'h0000_0042, 32'h0, 5'd3, 2'd1, 1'b0, 1'b1, 1'b0);
        #3 reset = 1'b0;
        #1 chk_reset_vals("rst_stall");
        @(negedge clk);
        #1 reset = 1'b1;

        // five flushes, one also stalled
        for (int i = 0; i < 5; i++) begin
            cyc(32'h4444_0000, 32'h0000_3300 + 32'(4 * i), 32'h0000_0001, 32'h0, 5'd4, 2'd1, 1'b0,
                (i == 2) ? 1'b1 : 1'b0, 1'b1);
        end
        chk("flushes_pc", M_PC, 32'h0000_3310);
`ifdef EM_BUBBLE_CNT_EN
        chk("bubble_cnt_5", bubble_cnt, 32'd5);
        #3 reset = 1'b0;
        #1 chk("bubble_cnt_rst", bubble_cnt, 32'd0);
        @(negedge clk);
        #1 reset = 1'b1;
`endif

        cyc(32'h3421_0007, 32'h0000_3400, 32'h0000_0007, 32'h0, 5'd1, 2'd1, 1'b0, 1'b0, 1'b0);
        chk("final_instr", M_instr, 32'h3421_0007);
        @(negedge clk);
        #1;
        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
